// File: rtl/fxp_pkg.sv
// Shared definitions for the signed fixed-point conversion path.
package fxp_pkg;

  // Rounding-mode encoding. Only round-to-nearest, ties toward +inf exists.
  localparam logic [1:0] RND_NEAREST_UP = 2'd0;

  // Signed saturation bounds for an N-bit two's-complement word.
  typedef struct packed {
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
  } fxp_limits_t;

  function automatic fxp_limits_t fxp_sat_limits(input int n);
    fxp_limits_t r;
    r.max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
    r.min_v = -(64'sd1 <<< (n - 1));
    return r;
  endfunction

  // Binary-point shift: positive means move left (gain fraction bits).
  function automatic int fxp_shift(input int in_point, input int out_point);
    return out_point - in_point;
  endfunction

  // Width of the aligned S1 value; one guard bit above the input either way.
  function automatic int fxp_align_width(input int n_in, input int sh);
    return (sh >= 0) ? n_in + sh + 1 : n_in + 1;
  endfunction

endpackage

// File: rtl/fxp_round_shift.sv
// Combinational binary-point alignment with round-to-nearest (ties to +inf).
// The shift direction and amount are fixed at elaboration.
module fxp_round_shift
  import fxp_pkg::*;
#(
  parameter int         N_IN      = 10,
  parameter int         IN_POINT  = 4,
  parameter int         OUT_POINT = 3,
  parameter logic [1:0] RND_MODE  = RND_NEAREST_UP,
  parameter int         W         = fxp_align_width(N_IN, fxp_shift(IN_POINT, OUT_POINT))
) (
  input  logic signed [N_IN-1:0] x_i,
  output logic signed [W-1:0]    y_o
);

  localparam int SH = fxp_shift(IN_POINT, OUT_POINT);

  generate
    if (SH >= 0) begin : g_left
      // Gaining fraction bits is exact: sign-extend, then shift.
      logic signed [W-1:0] x_ext;
      assign x_ext = W'(x_i);
      assign y_o   = x_ext <<< SH;
    end else begin : g_right
      // Dropping R fraction bits: add half an output LSB, then floor-shift.
      // The extra top bit keeps the add from overflowing at the extremes.
      localparam int R = -SH;
      localparam logic signed [N_IN:0] HALF =
        (RND_MODE == RND_NEAREST_UP) ? ((N_IN + 1)'(1) <<< (R - 1)) : '0;
      logic signed [N_IN:0] t;
      assign t   = (N_IN + 1)'(x_i) + HALF;
      assign y_o = W'(t >>> R);
    end
  endgenerate

endmodule

// File: rtl/signed_fixed_point_qconv.sv
// Two-stage valid/ready Q-format converter: S1 aligns/rounds, S2 saturates.
// Also counts delivered saturated results.
module signed_fixed_point_qconv
  import fxp_pkg::*;
#(
  parameter int N_IN      = 10,
  parameter int IN_POINT  = 4,
  parameter int N_OUT     = 10,
  parameter int OUT_POINT = 3,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N_IN-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N_OUT-1:0] out_data,
  output logic                    out_sat,
  input  logic                    sat_clr,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int                 SH    = fxp_shift(IN_POINT, OUT_POINT);
  localparam int                 W     = fxp_align_width(N_IN, SH);
  localparam fxp_limits_t        LIM   = fxp_sat_limits(N_OUT);
  localparam logic signed [63:0] MAX_L = LIM.max_v;
  localparam logic signed [63:0] MIN_L = LIM.min_v;

  logic                    adv1, adv2;
  logic signed [W-1:0]     aligned;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [W-1:0]     s1_data_q,  s1_data_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [N_OUT-1:0] s2_data_q,  s2_data_d;
  logic                    s2_sat_q,   s2_sat_d;
  logic signed [N_OUT-1:0] sat_data;
  logic                    sat_flag;
  logic [CNT_W-1:0]        sat_count_q, sat_count_d;

  fxp_round_shift #(
    .N_IN      (N_IN),
    .IN_POINT  (IN_POINT),
    .OUT_POINT (OUT_POINT),
    .RND_MODE  (RND_NEAREST_UP),
    .W         (W)
  ) u_round_shift (
    .x_i (in_data),
    .y_o (aligned)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // Clip the aligned value into the N_OUT range and flag any clipping.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sat_data = N_OUT'(s1_data_q);
    sat_flag = 1'b0;
    if (64'(s1_data_q) > MAX_L) begin
      sat_data = N_OUT'(MAX_L);
      sat_flag = 1'b1;
    end else if (64'(s1_data_q) < MIN_L) begin
      sat_data = N_OUT'(MIN_L);
      sat_flag = 1'b1;
    end
  end

  // Pipeline next state: each stage loads on advance, otherwise holds.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      s1_data_d  = aligned;
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = sat_data;
      s2_sat_d   = sat_flag;
    end
  end

  // Saturation counter: clear wins, otherwise count delivered clips, sticky at max.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid && out_ready && out_sat && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  // State registers for both stages and the counter.
  // NOTE: sequential state uses non-blocking assignments so stages update together.
  // NOTE: datapath registers are reset as well, so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_signed_fixed_point_qconv.sv
// Scoreboard bench: default Q6.4->Q7.3 converter (a) and a Q6.4->Q4.4 8-bit one (b).
module tb_signed_fixed_point_qconv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              iv_a, ir_a, ov_a, or_a, os_a, clr_a;
  logic signed [9:0] id_a, od_a;
  logic [15:0]       sc_a;
  logic              iv_b, ir_b, ov_b, or_b, os_b, clr_b;
  logic signed [9:0] id_b;
  logic signed [7:0] od_b;
  logic [15:0]       sc_b;

  signed_fixed_point_qconv u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_sat(os_a),
    .sat_clr(clr_a), .sat_count(sc_a)
  );

  signed_fixed_point_qconv #(.N_OUT(8), .OUT_POINT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_sat(os_b),
    .sat_clr(clr_b), .sat_count(sc_b)
  );

  typedef struct {
    longint data;
    bit     sat;
    int     cyc;
    bit     chk_lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor a: pop on each transfer, verify hold values while stalled.
  always @(negedge clk) begin
    if (rst_n && ov_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected actual %0d required no_output", od_a);
      end else if (or_a) begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", od_a, e.data);
        check("a_sat", os_a, e.sat);
        if (e.chk_lat) check("a_latency", cyc, e.cyc);
      end else begin
        check("a_hold_data", od_a, q_a[0].data);
        check("a_hold_sat", os_a, q_a[0].sat);
      end
    end
  end

  // Monitor b: same scheme for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && ov_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual %0d required no_output", od_b);
      end else if (or_b) begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", od_b, e.data);
        check("b_sat", os_b, e.sat);
        if (e.chk_lat) check("b_latency", cyc, e.cyc);
      end else begin
        check("b_hold_data", od_b, q_b[0].data);
        check("b_hold_sat", os_b, q_b[0].sat);
      end
    end
  end

  // Present one word and hold it until accepted; called at posedge+1.
  task automatic send(input bit sel, input int d, input longint exp_d,
                      input bit exp_s, input bit chk);
    exp_t e;
    int   n;
    bit   acc;
    e.data = exp_d; e.sat = exp_s; e.cyc = cyc + 2; e.chk_lat = chk;
    if (sel) begin q_b.push_back(e); iv_b = 1'b1; id_b = 10'(d); end
    else     begin q_a.push_back(e); iv_a = 1'b1; id_a = 10'(d); end
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = sel ? ir_b : ir_a;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual not_accepted required accepted word %0d", d);
    end
    if (sel) iv_b = 1'b0; else iv_a = 1'b0;
  endtask

  // Wait until every expected word of one instance has been delivered.
  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if ((sel ? q_b.size() : q_a.size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual %0d pending required 0 pending",
               sel ? q_b.size() : q_a.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual still_running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    iv_a = 0; id_a = '0; or_a = 1; clr_a = 0;
    iv_b = 0; id_b = '0; or_b = 1; clr_b = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    check("rst_in_ready_a", ir_a, 1);  check("rst_in_ready_b", ir_b, 1);
    check("rst_out_valid_a", ov_a, 0); check("rst_out_valid_b", ov_b, 0);
    check("rst_out_data_a", od_a, 0);  check("rst_out_data_b", od_b, 0);
    check("rst_out_sat_a", os_a, 0);   check("rst_out_sat_b", os_b, 0);
    check("rst_count_a", sc_a, 0);     check("rst_count_b", sc_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back rounding, 2-cycle latency (83 and -83 are ties).
    send(0, 80, 40, 0, 1);
    send(0, 83, 42, 0, 1);
    send(0, -83, -41, 0, 1);
    send(0, -20, -10, 0, 1);
    drain(0);
    check("count_a_basic", sc_a, 0);

    // Input extremes and zero.
    send(0, 511, 256, 0, 1);
    send(0, -512, -256, 0, 1);
    send(0, 0, 0, 0, 1);
    drain(0);

    // 8-bit output saturation in both directions.
    send(1, 300, 127, 1, 1);
    send(1, -300, -128, 1, 1);
    send(1, 100, 100, 0, 1);
    drain(1);
    check("count_b_two", sc_b, 2);

    // Backpressure: out_ready low for 5 clocks while 4 words stream in.
    or_a = 1'b0;
    fork
      begin
        send(0, 16, 8, 0, 0);
        send(0, -16, -8, 0, 0);
        send(0, 7, 4, 0, 0);
        send(0, -7, -3, 0, 0);
      end
      begin
        @(negedge clk); check("bp_ready_c0", ir_a, 1);
        @(negedge clk); check("bp_ready_c1", ir_a, 1);
        @(negedge clk); check("bp_ready_c2", ir_a, 0);
        repeat (3) @(posedge clk);
        #1;
        or_a = 1'b1;
      end
    join
    drain(0);

    // sat_clr coinciding with a saturated transfer wins.
    or_b = 1'b0;
    send(1, 300, 127, 1, 0);
    n = 0;
    while (!ov_b && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("b_stalled_valid", ov_b, 1);
    or_b = 1'b1; clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    check("count_clr_priority", sc_b, 0);
    send(1, -300, -128, 1, 0);
    drain(1);
    check("count_after_clr", sc_b, 1);

    // Asynchronous reset with two words in flight.
    send(0, 40, 20, 0, 0);
    send(0, -40, -20, 0, 0);
    check("inflight_valid_a", ov_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid_a", ov_a, 0);
    check("arst_out_data_a", od_a, 0);
    check("arst_count_b", sc_b, 0);
    check("arst_in_ready_a", ir_a, 1);
    q_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 48, 24, 0, 1);
    drain(0);
    check("post_reset_empty_a", q_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
